adder_pipe: RTL and testbench



---
 rtl/adder_pkg.sv | 22 ++
 rtl/adder_seg.sv | 29 ++
 rtl/adder_pipe.sv | 112 +++++++++++
 tb/tb_adder_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined segmented adder/subtractor.
package adder_pkg;

    localparam int MAX_W = 64;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // One pipeline stage: resolved low sum bits, running carry and the operands still to be consumed.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [MAX_W-1:0] sum_lo;
        logic [MAX_W-1:0] a_hi;
        logic [MAX_W-1:0] b_hi;
    } stage_rec_t;

    function automatic int nstage(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple-carry slice; also exposes the carry into its MSB for overflow detection.
module adder_seg
    import adder_pkg::*;
#(
    parameter int SEG = 2
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb_in
);

    logic [SEG:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co       = c[SEG];
        c_msb_in = c[SEG-1];
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined adder/subtractor resolving SEG bits per stage with a whole-pipe valid/ready stall.
// Define ADDER_OVF_EN to register a two's-complement overflow flag; otherwise Ovf is tied low.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEG   = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NSTAGE = nstage(WIDTH, SEG);

    if (WIDTH < 1 || WIDTH > MAX_W) begin : g_bad_width
        $error("adder_pipe: WIDTH must be between 1 and MAX_W");
    end
    if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_seg
        $error("adder_pipe: WIDTH must be a multiple of SEG");
    end

    logic       advance;
    stage_rec_t fin;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        stage_rec_t     r_in;
        stage_rec_t     r_nx;
        stage_rec_t     rec_p;
        logic [SEG-1:0] s_seg;
        logic           co;
        logic           c_msb;
        logic           unused_cmsb;

        // Stage 0 takes the operands straight from the input port; subtraction becomes A + ~B + ~Cin.
        if (k == 0) begin : g_first
            always_comb begin
                r_in                   = '0;
                r_in.valid             = In_valid;
                r_in.carry             = (Sub == ADD) ? Cin : ~Cin;
                r_in.a_hi[WIDTH-1:0]   = A;
                r_in.b_hi[WIDTH-1:0]   = (Sub == SUB) ? ~B : B;
            end
        end else begin : g_next
            assign r_in = g_stage[k-1].rec_p;
        end

        adder_seg #(.SEG(SEG)) u_seg (
            .a        (r_in.a_hi[k*SEG +: SEG]),
            .b        (r_in.b_hi[k*SEG +: SEG]),
            .ci       (r_in.carry),
            .s        (s_seg),
            .co       (co),
            .c_msb_in (c_msb)
        );

        always_comb begin
            r_nx                       = r_in;
            r_nx.carry                 = co;
            r_nx.sum_lo[k*SEG +: SEG]  = s_seg;
        end

        // Stage k register boundary.
        always_ff @(posedge Clk) begin
            if (Rst) begin
                rec_p <= '0;
            end else if (advance) begin
                rec_p <= r_nx;
            end
        end

        assign unused_cmsb = c_msb;
    end

    assign fin       = g_stage[NSTAGE-1].rec_p;
    assign advance   = !fin.valid || Out_ready;
    assign In_ready  = advance;
    assign Out_valid = fin.valid;
    assign S         = fin.sum_lo[WIDTH-1:0];
    assign Cout      = fin.carry;

`ifdef ADDER_OVF_EN
    logic ovf_p;

    // Overflow flag registered in lockstep with the final stage.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ovf_p <= 1'b0;
        end else if (advance) begin
            ovf_p <= g_stage[NSTAGE-1].c_msb ^ g_stage[NSTAGE-1].co;
        end
    end

    assign Ovf = ovf_p;
`else
    assign Ovf = 1'b0;
`endif

    logic unused_fin;
    assign unused_fin = ^{fin.a_hi, fin.b_hi, fin.sum_lo};

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: exhaustive 2-bit, latency, subtract, stall, reset and parameter sweep.
module tb_adder_pipe;

`ifdef ADDER_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Main instance: WIDTH=8, SEG=2
    logic       in_valid = 0, in_ready, cin = 0, sub = 0, out_valid, out_ready = 1, cout, ovf;
    logic [7:0] a = 0, b = 0, s;

    adder_pipe #(.WIDTH(8), .SEG(2)) dut (
        .Clk(clk), .Rst(rst), .In_valid(in_valid), .In_ready(in_ready), .A(a), .B(b),
        .Cin(cin), .Sub(sub), .Out_valid(out_valid), .Out_ready(out_ready), .S(s),
        .Cout(cout), .Ovf(ovf)
    );

    // Exhaustive instance: WIDTH=2, SEG=1
    logic       x_valid = 0, x_ir, x_cin = 0, x_ov, x_co, x_of;
    logic [1:0] x_a = 0, x_b = 0, x_s;

    adder_pipe #(.WIDTH(2), .SEG(1)) dut_x (
        .Clk(clk), .Rst(rst), .In_valid(x_valid), .In_ready(x_ir), .A(x_a), .B(x_b),
        .Cin(x_cin), .Sub(1'b0), .Out_valid(x_ov), .Out_ready(1'b1), .S(x_s),
        .Cout(x_co), .Ovf(x_of)
    );

    // Sweep instances share one 16-bit stimulus, each taking its low bits
    logic        sw_valid = 0, sw_cin = 0, sw_sub = 0;
    logic [15:0] sw_a = 0, sw_b = 0;
    logic        p16_ir, p16_ov, p16_co, p16_of;
    logic [15:0] p16_s;
    logic        p4_ir, p4_ov, p4_co, p4_of;
    logic [3:0]  p4_s;
    logic        p8_ir, p8_ov, p8_co, p8_of;
    logic [7:0]  p8_s;

    adder_pipe #(.WIDTH(16), .SEG(4)) dut_p16 (
        .Clk(clk), .Rst(rst), .In_valid(sw_valid), .In_ready(p16_ir), .A(sw_a), .B(sw_b),
        .Cin(sw_cin), .Sub(sw_sub), .Out_valid(p16_ov), .Out_ready(1'b1), .S(p16_s),
        .Cout(p16_co), .Ovf(p16_of)
    );

    adder_pipe #(.WIDTH(4), .SEG(1)) dut_p4 (
        .Clk(clk), .Rst(rst), .In_valid(sw_valid), .In_ready(p4_ir), .A(sw_a[3:0]), .B(sw_b[3:0]),
        .Cin(sw_cin), .Sub(sw_sub), .Out_valid(p4_ov), .Out_ready(1'b1), .S(p4_s),
        .Cout(p4_co), .Ovf(p4_of)
    );

    adder_pipe #(.WIDTH(8), .SEG(8)) dut_p8 (
        .Clk(clk), .Rst(rst), .In_valid(sw_valid), .In_ready(p8_ir), .A(sw_a[7:0]), .B(sw_b[7:0]),
        .Cin(sw_cin), .Sub(sw_sub), .Out_valid(p8_ov), .Out_ready(1'b1), .S(p8_s),
        .Cout(p8_co), .Ovf(p8_of)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference for the sweep: returns {ovf, cout, sum zero-extended to 16 bits}
    function automatic logic [17:0] ref_add(input int w, input logic [15:0] ra, input logic [15:0] rb,
                                            input logic rc, input logic rs);
        logic [16:0] mask, am, bm, sum;
        logic        c0, of;
        mask = (17'd1 << w) - 17'd1;
        am   = {1'b0, ra} & mask;
        bm   = (rs ? {1'b0, ~rb} : {1'b0, rb}) & mask;
        c0   = rs ? ~rc : rc;
        sum  = am + bm + {16'd0, c0};
        of   = (am[w-1] == bm[w-1]) && (sum[w-1] != am[w-1]);
        return {OVF_ON & of, sum[w], sum[15:0] & mask[15:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else passes++;
        checks++; if (s !== 8'h00) $display("FAIL rst_s: got %h want 00", s); else passes++;
        checks++; if (cout !== 1'b0) $display("FAIL rst_cout: got %b want 0", cout); else passes++;
        checks++; if (ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ovf); else passes++;
        checks++;
        if ({x_ov, p16_ov, p4_ov, p8_ov} !== 4'b0000)
            $display("FAIL rst_others_valid: got %b want 0000", {x_ov, p16_ov, p4_ov, p8_ov});
        else passes++;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passes++;
    endtask

    task automatic test_exhaustive();
        logic [2:0] exp3;
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v       = 5'(i);
            x_a     = v[4:3];
            x_b     = v[2:1];
            x_cin   = v[0];
            x_valid = 1'b1;
            tick();
            x_valid = 1'b0;
            tick();
            exp3 = {1'b0, v[4:3]} + {1'b0, v[2:1]} + {2'b00, v[0]};
            checks++;
            if (!(x_ov === 1'b1 && {x_co, x_s} === exp3))
                $display("FAIL exh_%0d: valid=%b {cout,s}=%b want valid=1 %b", i, x_ov, {x_co, x_s}, exp3);
            else passes++;
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
        in_valid = 1'b1; a = 8'hFF; b = 8'h01;
        tick();
        a = 8'h7F; b = 8'h01;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL lat_early: got valid=%b want 0", out_valid); else passes++;
        tick();
        checks++;
        if (!(out_valid === 1'b1 && s === 8'h00 && cout === 1'b1 && ovf === 1'b0))
            $display("FAIL lat_r0: got v=%b s=%h c=%b o=%b want v=1 s=00 c=1 o=0", out_valid, s, cout, ovf);
        else passes++;
        tick();
        checks++;
        if (!(out_valid === 1'b1 && s === 8'h80 && cout === 1'b0 && ovf === OVF_ON))
            $display("FAIL lat_r1: got v=%b s=%h c=%b o=%b want v=1 s=80 c=0 o=%b", out_valid, s, cout, ovf, OVF_ON);
        else passes++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL lat_drain: got valid=%b want 0", out_valid); else passes++;
    endtask

    task automatic test_subtract();
        out_ready = 1'b1; sub = 1'b1;
        in_valid = 1'b1; a = 8'h05; b = 8'h07; cin = 1'b0;
        tick();
        a = 8'h07; b = 8'h05; cin = 1'b1;
        tick();
        in_valid = 1'b0; sub = 1'b0; cin = 1'b0;
        tick();
        tick();
        checks++;
        if (!(out_valid === 1'b1 && s === 8'hFE && cout === 1'b0 && ovf === 1'b0))
            $display("FAIL sub_borrow: got v=%b s=%h c=%b o=%b want v=1 s=fe c=0 o=0", out_valid, s, cout, ovf);
        else passes++;
        tick();
        checks++;
        if (!(out_valid === 1'b1 && s === 8'h01 && cout === 1'b1 && ovf === 1'b0))
            $display("FAIL sub_noborrow: got v=%b s=%h c=%b o=%b want v=1 s=01 c=1 o=0", out_valid, s, cout, ovf);
        else passes++;
        tick();
    endtask

    task automatic test_back_pressure();
        logic [7:0] va [6] = '{8'h01, 8'h80, 8'hF0, 8'h33, 8'hFF, 8'h55};
        logic [7:0] vb [6] = '{8'h02, 8'h80, 8'h20, 8'h44, 8'hFF, 8'hAA};
        logic [8:0] ve [6] = '{9'h003, 9'h100, 9'h110, 9'h077, 9'h1FE, 9'h0FF};
        int   sent = 0, got = 0, stall = 0, cyc = 0;
        logic acc;
        logic [7:0] held = 8'h00;
        sub = 1'b0; cin = 1'b0;
        while (got < 6 && cyc < 60) begin
            out_ready = !(got == 1 && stall < 3);
            in_valid  = (sent < 6);
            a = va[sent % 6];
            b = vb[sent % 6];
            #1;
            if (!out_ready) begin
                checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d: got %b want 0", stall, in_ready); else passes++;
                if (stall == 0) held = s;
                else begin
                    checks++; if (s !== held) $display("FAIL bp_hold_%0d: got %h want %h", stall, s, held); else passes++;
                end
                stall++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if ({cout, s} !== ve[got]) $display("FAIL bp_res_%0d: got %h want %h", got, {cout, s}, ve[got]);
                else passes++;
                got++;
            end
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 6) $display("FAIL bp_count: got %0d results want 6", got); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_extra: got valid=%b want 0", out_valid); else passes++;
    endtask

    task automatic test_reset_midflight();
        logic seen;
        out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
        in_valid = 1'b1; a = 8'h11; b = 8'h22;
        tick();
        a = 8'h33; b = 8'h44;
        tick();
        a = 8'h55; b = 8'h66;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (!(out_valid === 1'b0 && s === 8'h00 && cout === 1'b0))
            $display("FAIL rstmid_out: got v=%b s=%h c=%b want v=0 s=00 c=0", out_valid, s, cout);
        else passes++;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL rstmid_dropped: got valid seen=%b want 0", seen); else passes++;
        in_valid = 1'b1; a = 8'h12; b = 8'h34;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_early: got valid=%b want 0", out_valid); else passes++;
        tick();
        checks++;
        if (!(out_valid === 1'b1 && s === 8'h46 && cout === 1'b0))
            $display("FAIL rstmid_new: got v=%b s=%h c=%b want v=1 s=46 c=0", out_valid, s, cout);
        else passes++;
        tick();
    endtask

    task automatic test_sweep();
        logic [17:0] e16, e4, e8, g16, g4, g8;
        int l16, l4, l8;
        for (int v = 0; v < 6; v++) begin
            sw_a   = 16'($urandom);
            sw_b   = 16'($urandom);
            sw_cin = 1'($urandom);
            sw_sub = 1'($urandom);
            e16 = ref_add(16, sw_a, sw_b, sw_cin, sw_sub);
            e4  = ref_add(4,  sw_a, sw_b, sw_cin, sw_sub);
            e8  = ref_add(8,  sw_a, sw_b, sw_cin, sw_sub);
            sw_valid = 1'b1;
            tick();
            sw_valid = 1'b0;
            l16 = -1; l4 = -1; l8 = -1;
            g16 = '0; g4 = '0; g8 = '0;
            for (int c = 1; c <= 8; c++) begin
                if (p16_ov && l16 < 0) begin l16 = c; g16 = {p16_of, p16_co, p16_s}; end
                if (p4_ov  && l4  < 0) begin l4  = c; g4  = {p4_of, p4_co, 12'h000, p4_s}; end
                if (p8_ov  && l8  < 0) begin l8  = c; g8  = {p8_of, p8_co, 8'h00, p8_s}; end
                tick();
            end
            checks++; if (l16 != 4) $display("FAIL sw16_lat_%0d: got %0d want 4", v, l16); else passes++;
            checks++; if (g16 !== e16) $display("FAIL sw16_res_%0d: got %h want %h", v, g16, e16); else passes++;
            checks++; if (l4 != 4) $display("FAIL sw4_lat_%0d: got %0d want 4", v, l4); else passes++;
            checks++; if (g4 !== e4) $display("FAIL sw4_res_%0d: got %h want %h", v, g4, e4); else passes++;
            checks++; if (l8 != 1) $display("FAIL sw8_lat_%0d: got %0d want 1", v, l8); else passes++;
            checks++; if (g8 !== e8) $display("FAIL sw8_res_%0d: got %h want %h", v, g8, e8); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_latency();
        test_subtract();
        test_back_pressure();
        test_reset_midflight();
        test_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
